// File: rtl/hw_avmm_host_fsm.sv
// Single-outstanding Avalon-MM host: turns one-cycle read/write requests into
// Avalon-MM bus cycles and returns read data behind a registered ready flag.
module hw_avmm_host_fsm #(
  parameter int unsigned P_ADDR_WIDTH = 4,
  parameter int unsigned P_DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    do_read,
  input  logic                    do_write,
  input  logic [P_ADDR_WIDTH-1:0] address,
  input  logic [P_DATA_WIDTH-1:0] data_wr,
  output logic                    ready,
  output logic [P_DATA_WIDTH-1:0] data_rd,
  output logic [P_ADDR_WIDTH-1:0] avmm_address,
  output logic                    avmm_write,
  output logic [P_DATA_WIDTH-1:0] avmm_writedata,
  output logic                    avmm_read,
  input  logic [P_DATA_WIDTH-1:0] avmm_readdata,
  input  logic                    avmm_readdatavalid,
  input  logic                    avmm_waitrequest
);

  typedef enum logic [1:0] {
    StIdle,
    StWrReq,
    StRdReq,
    StRdWait
  } state_e;

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    read_q, read_d;
  logic                    write_q, write_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [P_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [P_DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
        // Write wins over a simultaneous read; the read is simply dropped.
        if (do_write) begin
          addr_d  = address;
          wdata_d = data_wr;
          write_d = 1'b1;
          ready_d = 1'b0;
          state_d = StWrReq;
        end else if (do_read) begin
          addr_d  = address;
          read_d  = 1'b1;
          ready_d = 1'b0;
          state_d = StRdReq;
        end
      end

      StWrReq: begin
        if (!avmm_waitrequest) begin
          write_d = 1'b0;
          ready_d = 1'b1;
          state_d = StIdle;
        end
      end

      StRdReq: begin
        // readdatavalid only counts once the slave has accepted the command.
        if (!avmm_waitrequest) begin
          read_d = 1'b0;
          if (avmm_readdatavalid) begin
            rdata_d = avmm_readdata;
            ready_d = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StRdWait;
          end
        end
      end

      StRdWait: begin
        if (avmm_readdatavalid) begin
          rdata_d = avmm_readdata;
          ready_d = 1'b1;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        ready_d = 1'b1;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ready_q <= 1'b1;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready          = ready_q;
  assign data_rd        = rdata_q;
  assign avmm_address   = addr_q;
  assign avmm_write     = write_q;
  assign avmm_writedata = wdata_q;
  assign avmm_read      = read_q;

endmodule

// File: tb/tb_hw_avmm_host_fsm.sv
// Bench for hw_avmm_host_fsm: directed vector table, reset corner cases, then
// randomized traffic against a transaction-timing reference model.
module tb_hw_avmm_host_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        do_read, do_write;
  logic [3:0]  address;
  logic [31:0] data_wr;
  logic        ready;
  logic [31:0] data_rd;
  logic [3:0]  avmm_address;
  logic        avmm_write;
  logic [31:0] avmm_writedata;
  logic        avmm_read;
  logic [31:0] avmm_readdata;
  logic        avmm_readdatavalid;
  logic        avmm_waitrequest;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hw_avmm_host_fsm #(
    .P_ADDR_WIDTH(4),
    .P_DATA_WIDTH(32)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .do_read           (do_read),
    .do_write          (do_write),
    .address           (address),
    .data_wr           (data_wr),
    .ready             (ready),
    .data_rd           (data_rd),
    .avmm_address      (avmm_address),
    .avmm_write        (avmm_write),
    .avmm_writedata    (avmm_writedata),
    .avmm_read         (avmm_read),
    .avmm_readdata     (avmm_readdata),
    .avmm_readdatavalid(avmm_readdatavalid),
    .avmm_waitrequest  (avmm_waitrequest)
  );

  typedef struct {
    logic        do_rd;
    logic        do_wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        wreq;
    logic        rdv;
    logic [31:0] rdata;
    logic        e_ready;
    logic        e_read;
    logic        e_write;
    logic [3:0]  e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [3:0] a,
                              input logic [31:0] wd, input logic wq, input logic v,
                              input logic [31:0] rdt, input logic er, input logic erd,
                              input logic ewr, input logic [3:0] ea, input logic [31:0] ewd,
                              input logic [31:0] erdt);
    vec_t x;
    x.do_rd = rd;  x.do_wr = wr;  x.addr = a;  x.wdata = wd;
    x.wreq = wq;   x.rdv = v;     x.rdata = rdt;
    x.e_ready = er; x.e_read = erd; x.e_write = ewr;
    x.e_addr = ea; x.e_wdata = ewd; x.e_rdata = erdt;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_ready, input logic e_read,
                         input logic e_write, input logic [3:0] e_addr,
                         input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    chk({tag, ".ready"}, 32'(ready), 32'(e_ready));
    chk({tag, ".avmm_read"}, 32'(avmm_read), 32'(e_read));
    chk({tag, ".avmm_write"}, 32'(avmm_write), 32'(e_write));
    chk({tag, ".avmm_address"}, 32'(avmm_address), 32'(e_addr));
    chk({tag, ".avmm_writedata"}, avmm_writedata, e_wdata);
    chk({tag, ".data_rd"}, data_rd, e_rdata);
  endtask

  task automatic idle_inputs();
    do_read = 1'b0; do_write = 1'b0; address = '0; data_wr = '0;
    avmm_readdata = '0; avmm_readdatavalid = 1'b0; avmm_waitrequest = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vecs[16];

  // Reference model state: one pending transaction described by its timing plan.
  bit          m_busy, m_wr;
  int          m_t, m_w, m_l, m_done;
  logic        x_ready, x_read, x_write;
  logic [3:0]  x_addr;
  logic [31:0] x_wdata, x_rdata;

  initial begin
    vecs[0]  = mk(0, 1, 4'd1, 32'h11, 0, 0, 32'h0,      0, 0, 1, 4'd1, 32'h11, 32'h0);
    vecs[1]  = mk(0, 1, 4'd7, 32'h99, 0, 0, 32'h0,      1, 0, 0, 4'd1, 32'h11, 32'h0);
    vecs[2]  = mk(1, 0, 4'd2, 32'h0,  1, 0, 32'h0,      0, 1, 0, 4'd2, 32'h11, 32'h0);
    vecs[3]  = mk(0, 0, 4'd0, 32'h0,  1, 0, 32'h0,      0, 1, 0, 4'd2, 32'h11, 32'h0);
    vecs[4]  = mk(0, 0, 4'd0, 32'h0,  1, 0, 32'h0,      0, 1, 0, 4'd2, 32'h11, 32'h0);
    vecs[5]  = mk(0, 0, 4'd0, 32'h0,  1, 0, 32'h0,      0, 1, 0, 4'd2, 32'h11, 32'h0);
    vecs[6]  = mk(0, 0, 4'd0, 32'h0,  0, 0, 32'h0,      0, 0, 0, 4'd2, 32'h11, 32'h0);
    vecs[7]  = mk(0, 0, 4'd0, 32'h0,  0, 0, 32'h0,      0, 0, 0, 4'd2, 32'h11, 32'h0);
    vecs[8]  = mk(0, 0, 4'd0, 32'h0,  0, 1, 32'h4,      1, 0, 0, 4'd2, 32'h11, 32'h4);
    vecs[9]  = mk(1, 0, 4'd3, 32'h0,  0, 0, 32'h0,      0, 1, 0, 4'd3, 32'h11, 32'h4);
    vecs[10] = mk(0, 0, 4'd0, 32'h0,  0, 1, 32'hDEADBEEF, 1, 0, 0, 4'd3, 32'h11, 32'hDEADBEEF);
    vecs[11] = mk(1, 1, 4'd5, 32'h55, 0, 0, 32'h0,      0, 0, 1, 4'd5, 32'h55, 32'hDEADBEEF);
    vecs[12] = mk(1, 0, 4'd0, 32'h0,  1, 0, 32'h0,      0, 0, 1, 4'd5, 32'h55, 32'hDEADBEEF);
    vecs[13] = mk(0, 0, 4'd0, 32'h0,  0, 0, 32'h0,      1, 0, 0, 4'd5, 32'h55, 32'hDEADBEEF);
    vecs[14] = mk(0, 0, 4'd0, 32'h0,  0, 1, 32'h1234,   1, 0, 0, 4'd5, 32'h55, 32'hDEADBEEF);
    vecs[15] = mk(0, 0, 4'd0, 32'h0,  0, 0, 32'h0,      1, 0, 0, 4'd5, 32'h55, 32'hDEADBEEF);

    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    chk_all("reset", 1, 0, 0, 4'd0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: inputs held for one cycle, outputs checked after the edge.
    for (int r = 0; r < 16; r++) begin
      do_read            = vecs[r].do_rd;
      do_write           = vecs[r].do_wr;
      address            = vecs[r].addr;
      data_wr            = vecs[r].wdata;
      avmm_waitrequest   = vecs[r].wreq;
      avmm_readdatavalid = vecs[r].rdv;
      avmm_readdata      = vecs[r].rdata;
      @(negedge clk);
      chk_all($sformatf("vec%0d", r), vecs[r].e_ready, vecs[r].e_read, vecs[r].e_write,
              vecs[r].e_addr, vecs[r].e_wdata, vecs[r].e_rdata);
    end
    idle_inputs();

    // Reset while waiting for read data: everything returns to reset values at once.
    do_read = 1'b1; address = 4'd6;
    @(negedge clk);
    do_read = 1'b0; address = '0;
    @(negedge clk);
    chk("rdwait.ready_low", 32'(ready), 32'd0);
    reset = 1'b1;
    #1;
    chk_all("rst_rdwait", 1, 0, 0, 4'd0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    avmm_readdatavalid = 1'b1; avmm_readdata = 32'hABCD;
    @(negedge clk);
    avmm_readdatavalid = 1'b0; avmm_readdata = '0;
    chk_all("late_rdv", 1, 0, 0, 4'd0, 32'h0, 32'h0);

    // Reset while the read strobe is stalled drops the strobe without a clock edge.
    do_read = 1'b1; address = 4'd9; avmm_waitrequest = 1'b1;
    @(negedge clk);
    do_read = 1'b0;
    chk("rdreq.avmm_read", 32'(avmm_read), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_rdreq.avmm_read", 32'(avmm_read), 32'd0);
    chk("rst_rdreq.ready", 32'(ready), 32'd1);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;

    // Randomized traffic. Each accepted transaction gets a plan of W waitrequest
    // cycles and (reads) L cycles of readdatavalid latency; cycle t counts from 1.
    m_busy = 0; m_wr = 0; m_t = 0; m_w = 0; m_l = 0; m_done = 0;
    x_ready = 1; x_read = 0; x_write = 0; x_addr = '0; x_wdata = '0; x_rdata = '0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      chk_all("rnd", x_ready, x_read, x_write, x_addr, x_wdata, x_rdata);

      do_read       = ($urandom_range(0, 3) == 0);
      do_write      = ($urandom_range(0, 3) == 0);
      address       = 4'($urandom);
      data_wr       = $urandom;
      avmm_readdata = $urandom;
      if (m_busy) begin
        avmm_waitrequest   = (m_t <= m_w);
        avmm_readdatavalid = m_wr ? 1'($urandom) : (m_t == m_w + 1 + m_l);
      end else begin
        avmm_waitrequest   = 1'($urandom);
        avmm_readdatavalid = 1'($urandom);
      end

      if (m_busy) begin
        if (m_t == m_done) begin
          m_busy = 0;
          if (!m_wr) x_rdata = avmm_readdata;
        end else begin
          m_t++;
        end
      end else if (do_write || do_read) begin
        m_busy = 1;
        m_wr   = do_write;
        m_t    = 1;
        m_w    = $urandom_range(0, 3);
        m_l    = $urandom_range(0, 3);
        m_done = m_wr ? m_w + 1 : m_w + 1 + m_l;
        x_addr = address;
        if (m_wr) x_wdata = data_wr;
      end
      x_ready = !m_busy;
      x_write = m_busy && m_wr && (m_t <= m_w + 1);
      x_read  = m_busy && !m_wr && (m_t <= m_w + 1);
    end
    @(negedge clk);
    chk_all("rnd_end", x_ready, x_read, x_write, x_addr, x_wdata, x_rdata);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hw_avmm_host_fsm.md
# hw_avmm_host_fsm

Single-transaction Avalon-MM host that turns one-cycle `do_read`/`do_write` requests into Avalon-MM read/write cycles toward the mailbox client. It sits between the health-monitor control FSM and the mailbox client's 32-bit CSR slave. It also returns read data with a registered `ready` handshake. Only one transaction is outstanding at a time; requests arriving while busy are dropped.

## Interface
- `P_ADDR_WIDTH`, default 4, word-address width
- `P_DATA_WIDTH`, default 32, data width
- `clk  in  1` — single clock; all logic is rising-edge
- `reset  in  1` — asynchronous, active-high reset
- `do_read  in  1` — read request; sampled only while `ready`=1
- `do_write  in  1` — write request; sampled only while `ready`=1
- `address  in  P_ADDR_WIDTH` — word address, latched at acceptance
- `data_wr  in  P_DATA_WIDTH` — write data, latched at acceptance
- `ready  out  1` — registered; 1 = idle, will accept a request
- `data_rd  out  P_DATA_WIDTH` — last read data, held until the next read completes
- `avmm_address  out  P_ADDR_WIDTH` — Avalon address
- `avmm_write  out  1` — Avalon write strobe
- `avmm_writedata  out  P_DATA_WIDTH` — Avalon write data
- `avmm_read  out  1` — Avalon read strobe
- `avmm_readdata  in  P_DATA_WIDTH` — Avalon read data
- `avmm_readdatavalid  in  1` — read data valid (pipelined read)
- `avmm_waitrequest  in  1` — slave stall

## Operation
- States:
  - IDLE
  - WR_REQ (write strobe held)
  - RD_REQ (read strobe held)
  - RD_WAIT (awaiting `readdatavalid`)
- IDLE, `ready`=1:
  - `do_write`=1 → latch `address`/`data_wr` into `avmm_address`/`avmm_writedata`; `avmm_write`<=1; `ready`<=0; go to WR_REQ.
  - else `do_read`=1 → latch `address`; `avmm_read`<=1; `ready`<=0; go to RD_REQ.
  - Write has priority when both requests are asserted; the read is dropped.
- WR_REQ: hold the strobe, address and data while `avmm_waitrequest`=1. On `avmm_waitrequest`=0 → `avmm_write`<=0, `ready`<=1, go to IDLE.
- RD_REQ: hold the strobe while `avmm_waitrequest`=1. On `avmm_waitrequest`=0:
  - `avmm_read`<=0.
  - If `avmm_readdatavalid`=1 in the same cycle → `data_rd`<=`avmm_readdata`, `ready`<=1, go to IDLE.
  - Otherwise go to RD_WAIT.
- RD_WAIT: on `avmm_readdatavalid`=1 → `data_rd`<=`avmm_readdata`, `ready`<=1, go to IDLE. No timeout.
- Dropped and ignored inputs:
  - `do_read`/`do_write` while `ready`=0 are ignored, not queued.
  - `avmm_readdatavalid` in IDLE or WR_REQ is ignored; `data_rd` is unchanged.
- Outputs and hold rules:
  - `data_rd` changes only on read completion.
  - A write leaves `data_rd` unchanged.
  - `avmm_address`/`avmm_writedata` keep their last values in IDLE.
- Only one of `avmm_read`/`avmm_write` is ever high.

## Timing
- Reset (async assert, sync release) values:
  - state=IDLE, `ready`=1
  - `avmm_read`=`avmm_write`=0
  - `avmm_address`=0, `avmm_writedata`=0, `data_rd`=0
- Reset mid-transaction drops the strobe immediately. A late `readdatavalid` after reset is ignored.
- Acceptance edge E: strobe and address are visible from cycle E+1; `ready` is 0 from E+1.
  - The caller may keep `do_*` high through E+1; it is ignored because `ready` is 0.
- Write, zero wait states: `avmm_write` high exactly 1 cycle (E+1); `ready`=1 from E+2.
  - Each waitrequest cycle adds 1 cycle.
- Read with waitrequest=0 at E+1 and readdatavalid at E+1+L (L≥0):
  - `avmm_read` is high 1 cycle.
  - `data_rd` valid and `ready`=1 from E+2+L.
- Back-to-back: a new request can be accepted on the first edge where `ready`=1. Minimum period is 2 cycles per write.

## Test plan
- Reset release, then write `do_write`=1, `address`=1, `data_wr`=0x0000_0011 with no waitrequest:
  - `avmm_write` high 1 cycle with address 1 and data 0x11; `ready` low 1 cycle.
- Read of address 2, waitrequest high 3 cycles, readdatavalid 2 cycles after the strobe drops with data 0x0000_0004:
  - `avmm_read` held 4 cycles.
  - `data_rd`=4 and `ready`=1 on the cycle after readdatavalid.
- Read with waitrequest=0 and readdatavalid in the same cycle as the strobe, data 0xDEAD_BEEF:
  - `data_rd`=0xDEADBEEF; `ready` back after 2 cycles.
- `do_read` and `do_write` together:
  - Only the write is issued; a `do_read` pulse while busy produces no second transaction.
- Write after a read:
  - `data_rd` keeps its prior value 0xDEADBEEF.
  - A spurious `readdatavalid` in IDLE with data 0x1234 leaves `data_rd` unchanged.
- Assert `reset` during RD_WAIT:
  - `avmm_read`=0, `ready`=1, `data_rd`=0 immediately.
  - A later `readdatavalid` is ignored.
